im_port_arbiter: RTL and testbench
==================================

# im_port_arbiter

Arbitrates the single-ported, synchronous-read instruction memory between the IF-stage fetch requester and the program loader, which writes words from the debug/boot path. It translates byte PCs into word indices, blocks out-of-range accesses, and guarantees fetch progress during long load bursts with a starvation counter. It sits between the IF stage and the instruction memory array.

## Interface
- `BASE_ADDR`, default 32'h0000_3000: byte address of IM word 0.
- `DEPTH_LOG2`, default 12: log2 of IM depth in words (4096 words).
- `MAX_BURST`, default 4: maximum consecutive loader grants while fetch is pending (1..15).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `f_req`  in  1  fetch request valid.
- `f_pc`  in  32  fetch byte address.
- `f_gnt`  out  1  fetch accepted this cycle (combinational).
- `f_rvalid`  out  1  fetch response valid, one cycle after `f_gnt`.
- `f_instr`  out  32  fetched word; valid with `f_rvalid`.
- `f_err`  out  1  with `f_rvalid`: the granted address was out of range or misaligned.
- `l_req`  in  1  loader write request valid.
- `l_addr`  in  32  loader byte address.
- `l_wdata`  in  32  loader write data.
- `l_gnt`  out  1  loader write accepted this cycle (combinational).
- `l_err`  out  1  one-cycle pulse, the cycle after an out-of-range or misaligned `l_gnt`.
- `m_en`  out  1  memory access enable.
- `m_we`  out  1  memory write enable; only asserted together with `m_en`.
- `m_addr`  out  DEPTH_LOG2  word index.
- `m_wdata`  out  32  memory write data.
- `m_rdata`  in  32  memory read data, valid the cycle after a read with `m_en=1`, `m_we=0`.

## Operation
- Offset `off = addr - BASE_ADDR` (32-bit, wrapping).
- Range check: an address is in range iff `off[31:DEPTH_LOG2+2] == 0` and `off[1:0] == 0`.
- Word index: `m_addr = off[DEPTH_LOG2+1:2]`.
- Grant rule (combinational):
  - `l_gnt = l_req & ~(f_req & cnt == MAX_BURST)`.
  - `f_gnt = f_req & ~l_gnt`.
  - Loader wins by default. Fetch wins when the burst limit is reached.
- Burst counter `cnt` (4 bits):
  - Increments on `l_gnt & f_req`.
  - Clears on `f_gnt` or when `f_req=0`.
  - Never exceeds MAX_BURST.
- Memory drive:
  - Granted and in range: `m_en=1`, `m_we=l_gnt`, `m_addr` and `m_wdata` from the granted port.
  - Otherwise `m_en=0`, `m_we=0`, `m_addr=0`, `m_wdata=0`.
  - An out-of-range grant still completes its handshake but issues no memory access.
- Response pipeline (one register stage):
  - `f_rvalid <= f_gnt`.
  - `oor_q <= f_gnt & ~in_range(f_pc)`.
  - `f_err = f_rvalid & oor_q`.
  - `f_instr = oor_q ? 32'h0 : m_rdata` when `f_rvalid`, else 0. An erroneous fetch returns a NOP.
- `l_err <= l_gnt & ~in_range(l_addr)`.
- Read-after-write: a write granted in cycle N is visible to a fetch granted in cycle N+1 or later.
- Reset (async, active-low) clears `cnt`, `f_rvalid`, `oor_q` and `l_err`.
- Reset mid-operation: an in-flight fetch response is discarded, with no `f_rvalid` after reset release.
- Memory contents are unaffected by reset.

## Timing
- Fetch latency: `f_gnt` in cycle N, then `f_rvalid`/`f_instr` in cycle N+1.
- Back-to-back fetches give one response per cycle.
- Loader write is committed at the edge that ends its `l_gnt` cycle.
- Requesters hold `req`, address and data until they see `gnt`. Dropping `req` without `gnt` is allowed and causes no access.
- Simultaneous `f_req` and `l_req` with `cnt < MAX_BURST`: the loader is granted and the fetch stalls.
- Worst-case fetch wait under continuous loader traffic is MAX_BURST cycles.
- With `MAX_BURST=4` and both requesting every cycle, the steady pattern is L,L,L,L,F repeating.
- All outputs are 0 during reset.
- `f_gnt`, `l_gnt` and the memory outputs are combinational from the inputs and `cnt`. They are 0 when no request is present.

## Test plan
- Fetch only, `f_pc=0x3000` then `0x3004`, with IM[0]=0x24080001 and IM[1]=0x24090002: `f_rvalid` in consecutive cycles with those words, `f_err=0`.
- Loader writes 0xDEADBEEF to 0x3010, then fetch `0x3010` the next cycle: `f_instr=0xDEADBEEF`.
- Both request continuously for 12 cycles, MAX_BURST=4: grant sequence L,L,L,L,F,L,L,L,L,F,L,L, and `cnt` clears after each F.
- Fetch `0x2FFC`, `0x7000` and `0x3002`: each granted, `m_en=0`, then `f_rvalid=1`, `f_err=1`, `f_instr=0`.
- Loader write to `0x7000`: `l_gnt=1`, `m_en=0`, `l_err=1` next cycle, IM unchanged.
- Assert `reset=0` in the cycle after `f_gnt`: `f_rvalid`, `f_err`, `l_err` and `cnt` are 0 immediately, and no stale response appears after release.

Source files
------------

// File: rtl/im_port_arbiter.sv
// Instruction-memory port arbiter: loader has priority, a burst counter forces a fetch through after MAX_BURST loader wins.
// Grants are combinational, fetch data returns one cycle after f_gnt; the losing requester simply holds its request.

module im_port_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [31:0]           f_pc,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [31:0]           f_instr,
  output logic                  f_err,
  input  logic                  l_req,
  input  logic [31:0]           l_addr,
  input  logic [31:0]           l_wdata,
  output logic                  l_gnt,
  output logic                  l_err,
  output logic                  m_en,
  output logic                  m_we,
  output logic [DEPTH_LOG2-1:0] m_addr,
  output logic [31:0]           m_wdata,
  input  logic [31:0]           m_rdata
);

  localparam int         AW        = DEPTH_LOG2 + 2;
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  // Offsets wrap, so addresses below BASE_ADDR land far out of range.
  function automatic logic in_range(input logic [31:0] off);
    return (off[31:AW] == '0) && (off[1:0] == 2'b00);
  endfunction

  logic [31:0] f_off;
  logic [31:0] l_off;
  logic        f_ok;
  logic        l_ok;
  logic        burst_hit;

  logic [3:0]  cnt_q, cnt_d;
  logic        f_rvalid_q, f_rvalid_d;
  logic        oor_q, oor_d;
  logic        l_err_q, l_err_d;

  // Grants are held low while reset is asserted so nothing reaches the array.
  always_comb begin
    f_off     = f_pc - BASE_ADDR;
    l_off     = l_addr - BASE_ADDR;
    f_ok      = in_range(f_off);
    l_ok      = in_range(l_off);
    burst_hit = f_req && (cnt_q == BURST_LIM);
    l_gnt     = reset && l_req && !burst_hit;
    f_gnt     = reset && f_req && !l_gnt;
  end

  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (l_gnt && l_ok) begin
      m_en    = 1'b1;
      m_we    = 1'b1;
      m_addr  = l_off[AW-1:2];
      m_wdata = l_wdata;
    end else if (f_gnt && f_ok) begin
      m_en    = 1'b1;
      m_addr  = f_off[AW-1:2];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!f_req || f_gnt) begin
      cnt_d = 4'd0;
    end else if (l_gnt && (cnt_q < BURST_LIM)) begin
      cnt_d = cnt_q + 4'd1;
    end
    f_rvalid_d = f_gnt;
    oor_d      = f_gnt && !f_ok;
    l_err_d    = l_gnt && !l_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= 4'd0;
      f_rvalid_q <= 1'b0;
      oor_q      <= 1'b0;
      l_err_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      f_rvalid_q <= f_rvalid_d;
      oor_q      <= oor_d;
      l_err_q    <= l_err_d;
    end
  end

  // A rejected fetch returns an all-zero word (NOP) alongside f_err.
  assign f_rvalid = f_rvalid_q;
  assign f_err    = f_rvalid_q && oor_q;
  assign f_instr  = (f_rvalid_q && !oor_q) ? m_rdata : 32'h0;
  assign l_err    = l_err_q;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Bench for im_port_arbiter: behavioural IM array, reference memory and a response scoreboard.
module tb_im_port_arbiter;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        f_req = 1'b0;
  logic [31:0] f_pc = '0;
  logic        f_gnt, f_rvalid, f_err;
  logic [31:0] f_instr;
  logic        l_req = 1'b0;
  logic [31:0] l_addr = '0;
  logic [31:0] l_wdata = '0;
  logic        l_gnt, l_err;
  logic        m_en, m_we;
  logic [11:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  logic [31:0] mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  exp_t        exp_q [$];
  int          n_tests = 0;
  int          n_fail = 0;

  logic        g_f, g_l, g_en, g_we;
  logic [11:0] g_addr;
  logic        r_v, r_e, r_le;
  logic [31:0] r_i;
  logic [3:0]  r_cnt;

  always #5 clk = ~clk;

  im_port_arbiter dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_pc(f_pc), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_instr(f_instr), .f_err(f_err),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt), .l_err(l_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata <= mem[m_addr];
    end
  end

  function automatic logic tb_in(input logic [31:0] a);
    return (a >= 32'h3000) && (a < 32'h7000) && (a[1:0] == 2'b00);
  endfunction

  function automatic int tb_idx(input logic [31:0] a);
    return int'((a - 32'h3000) >> 2);
  endfunction

  // One clock: drive, sample grants mid-cycle, record expectations, sample registered outputs after the edge.
  task automatic cyc(input logic fr, input logic [31:0] pc, input logic lr,
                     input logic [31:0] la, input logic [31:0] ld);
    @(negedge clk);
    f_req = fr; f_pc = pc; l_req = lr; l_addr = la; l_wdata = ld;
    #1;
    g_f = f_gnt; g_l = l_gnt; g_en = m_en; g_we = m_we; g_addr = m_addr;
    if (f_gnt) begin
      if (tb_in(pc)) exp_q.push_back({ref_mem[tb_idx(pc)], 1'b0});
      else           exp_q.push_back({32'h0, 1'b1});
    end
    if (l_gnt && tb_in(la)) ref_mem[tb_idx(la)] = ld;
    @(posedge clk);
    #1;
    r_v = f_rvalid; r_i = f_instr; r_e = f_err; r_le = l_err; r_cnt = dut.cnt_q;
  endtask

  task automatic test_reset();
    @(negedge clk);
    f_req = 1'b1; l_req = 1'b1; f_pc = 32'h3000; l_addr = 32'h3000; l_wdata = 32'h1;
    #1;
    n_tests++; if (f_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_f_gnt got=%b exp=0", f_gnt); end
    n_tests++; if (l_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_l_gnt got=%b exp=0", l_gnt); end
    n_tests++; if (m_en !== 1'b0 || m_we !== 1'b0) begin n_fail++; $display("FAIL reset_m_en got=%b/%b exp=0/0", m_en, m_we); end
    n_tests++; if (f_rvalid !== 1'b0 || f_err !== 1'b0 || l_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs got rv=%b fe=%b le=%b exp=0", f_rvalid, f_err, l_err); end
    n_tests++; if (f_instr !== 32'h0) begin n_fail++; $display("FAIL reset_f_instr got=%h exp=0", f_instr); end
    f_req = 1'b0; l_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_fetch();
    exp_t e;
    cyc(1'b0, 32'h0, 1'b1, 32'h3000, 32'h2408_0001);
    n_tests++; if (g_l !== 1'b1 || g_we !== 1'b1 || g_addr !== 12'd0) begin
      n_fail++; $display("FAIL fetch_load0 got gnt=%b we=%b addr=%0d exp 1/1/0", g_l, g_we, g_addr); end
    cyc(1'b0, 32'h0, 1'b1, 32'h3004, 32'h2409_0002);
    n_tests++; if (g_addr !== 12'd1) begin n_fail++; $display("FAIL fetch_load1_addr got=%0d exp=1", g_addr); end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 32'h0, 32'h0);
      n_tests++; if (g_f !== 1'b1 || g_en !== 1'b1 || g_we !== 1'b0) begin
        n_fail++; $display("FAIL fetch_gnt%0d got gnt=%b en=%b we=%b exp 1/1/0", i, g_f, g_en, g_we); end
      n_tests++; if (r_v !== 1'b1) begin n_fail++; $display("FAIL fetch_rvalid%0d got=%b exp=1", i, r_v); end
      if (r_v) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL fetch_rsp%0d unexpected response got=%h", i, r_i); end
        else begin
          e = exp_q.pop_front();
          if (r_i !== e.instr || r_e !== e.err) begin
            n_fail++; $display("FAIL fetch_rsp%0d got instr=%h err=%b exp instr=%h err=%b", i, r_i, r_e, e.instr, e.err); end
        end
      end
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    n_tests++; if (r_v !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL fetch_drain got rv=%b pending=%0d exp 0/0", r_v, exp_q.size()); end
  endtask

  task automatic test_raw();
    exp_t e;
    cyc(1'b0, 32'h0, 1'b1, 32'h3010, 32'hDEAD_BEEF);
    n_tests++; if (g_l !== 1'b1 || g_we !== 1'b1 || g_addr !== 12'd4) begin
      n_fail++; $display("FAIL raw_write got gnt=%b we=%b addr=%0d exp 1/1/4", g_l, g_we, g_addr); end
    cyc(1'b1, 32'h3010, 1'b0, 32'h0, 32'h0);
    n_tests++; if (r_v !== 1'b1 || r_i !== 32'hDEAD_BEEF || r_e !== 1'b0) begin
      n_fail++; $display("FAIL raw_read got rv=%b instr=%h err=%b exp 1/deadbeef/0", r_v, r_i, r_e); end
    if (r_v && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_tests++; if (r_i !== e.instr) begin n_fail++; $display("FAIL raw_sb got=%h exp=%h", r_i, e.instr); end
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_burst();
    exp_t        e;
    logic [31:0] fpc = 32'h3020;
    int          nl = 0;
    logic        exp_f;
    logic [3:0]  exp_cnt;
    cyc(1'b0, 32'h0, 1'b1, 32'h3020, 32'h1111_0000);
    cyc(1'b0, 32'h0, 1'b1, 32'h3024, 32'h2222_0000);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, fpc, 1'b1, 32'h3100 + 32'(4 * nl), 32'hA500_0000 + 32'(i));
      exp_f   = (i % 5) == 4;
      exp_cnt = exp_f ? 4'd0 : 4'((i % 5) + 1);
      n_tests++; if (g_f !== exp_f || g_l !== !exp_f) begin
        n_fail++; $display("FAIL burst_gnt%0d got f=%b l=%b exp f=%b l=%b", i, g_f, g_l, exp_f, !exp_f); end
      n_tests++; if (r_cnt !== exp_cnt) begin n_fail++; $display("FAIL burst_cnt%0d got=%0d exp=%0d", i, r_cnt, exp_cnt); end
      n_tests++; if (r_v !== exp_f) begin n_fail++; $display("FAIL burst_rvalid%0d got=%b exp=%b", i, r_v, exp_f); end
      if (r_v) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL burst_rsp%0d unexpected response got=%h", i, r_i); end
        else begin
          e = exp_q.pop_front();
          if (r_i !== e.instr || r_e !== e.err) begin
            n_fail++; $display("FAIL burst_rsp%0d got instr=%h err=%b exp instr=%h err=%b", i, r_i, r_e, e.instr, e.err); end
        end
      end
      if (g_f) fpc = fpc + 32'h4;
      if (g_l) nl++;
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    n_tests++; if (r_cnt !== 4'd0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL burst_end got cnt=%0d pending=%0d exp 0/0", r_cnt, exp_q.size()); end
  endtask

  task automatic test_oor_fetch();
    exp_t        e;
    logic [31:0] pcs [3] = '{32'h2FFC, 32'h7000, 32'h3002};
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, pcs[i], 1'b0, 32'h0, 32'h0);
      n_tests++; if (g_f !== 1'b1 || g_en !== 1'b0) begin
        n_fail++; $display("FAIL oorf_gnt_%h got gnt=%b en=%b exp 1/0", pcs[i], g_f, g_en); end
      n_tests++; if (r_v !== 1'b1 || r_e !== 1'b1 || r_i !== 32'h0) begin
        n_fail++; $display("FAIL oorf_rsp_%h got rv=%b err=%b instr=%h exp 1/1/0", pcs[i], r_v, r_e, r_i); end
      if (r_v && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_tests++; if (r_e !== e.err) begin n_fail++; $display("FAIL oorf_sb_%h got err=%b exp=%b", pcs[i], r_e, e.err); end
      end
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    n_tests++; if (r_v !== 1'b0 || r_e !== 1'b0) begin n_fail++; $display("FAIL oorf_drain got rv=%b err=%b exp 0/0", r_v, r_e); end
  endtask

  task automatic test_oor_load();
    logic [31:0] las [2] = '{32'h7000, 32'h3001};
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 32'h0, 1'b1, las[i], 32'h1234_5678);
      n_tests++; if (g_l !== 1'b1 || g_en !== 1'b0 || g_we !== 1'b0) begin
        n_fail++; $display("FAIL oorl_gnt_%h got gnt=%b en=%b we=%b exp 1/0/0", las[i], g_l, g_en, g_we); end
      n_tests++; if (r_le !== 1'b1) begin n_fail++; $display("FAIL oorl_err_%h got=%b exp=1", las[i], r_le); end
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      n_tests++; if (r_le !== 1'b0) begin n_fail++; $display("FAIL oorl_pulse_%h got=%b exp=0", las[i], r_le); end
    end
    n_tests++; if (mem[0] !== ref_mem[0] || mem[1] !== ref_mem[1]) begin
      n_fail++; $display("FAIL oorl_mem got=%h/%h exp=%h/%h", mem[0], mem[1], ref_mem[0], ref_mem[1]); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 32'h3000, 1'b1, 32'h7000, 32'h0);
    n_tests++; if (r_le !== 1'b1 || r_cnt !== 4'd1) begin
      n_fail++; $display("FAIL rstmid_setup got le=%b cnt=%0d exp 1/1", r_le, r_cnt); end
    reset = 1'b0;
    #1;
    n_tests++; if (l_err !== 1'b0 || dut.cnt_q !== 4'd0 || f_gnt !== 1'b0 || l_gnt !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_clear got le=%b cnt=%0d fg=%b lg=%b exp 0", l_err, dut.cnt_q, f_gnt, l_gnt); end
    exp_q.delete();
    f_req = 1'b0; l_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 32'h2FFC, 1'b0, 32'h0, 32'h0);
    n_tests++; if (g_f !== 1'b1 || r_v !== 1'b1) begin n_fail++; $display("FAIL rstmid_inflight got gnt=%b rv=%b exp 1/1", g_f, r_v); end
    reset = 1'b0;
    #1;
    n_tests++; if (f_rvalid !== 1'b0 || f_err !== 1'b0 || f_instr !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_rsp got rv=%b err=%b instr=%h exp 0", f_rvalid, f_err, f_instr); end
    exp_q.delete();
    f_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      n_tests++; if (r_v !== 1'b0 || r_e !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale%0d got rv=%b err=%b exp 0", i, r_v, r_e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_fetch();
    test_raw();
    test_burst();
    test_oor_fetch();
    test_oor_load();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
